// File: rtl/shift_reg_pkg.sv
// -----------------------------------------------------------------------------
// shift_reg_pkg
//
// Shared types and sizing helpers for the serial shift-register link
// transmitter (shift_reg_piso_tx) and its counter (shift_reg_piso_cnt).
//
// Contents:
//   state_t    : transmitter FSM states (IDLE, SHIFT, GAP), 2-bit encoding.
//   PARITY_BITS: 1 when the even-parity trailer is built in, else 0.
//   frame_len(): number of serial bits per frame for a given word width.
//   cnt_w()    : counter width large enough for both the frame bit index and
//                the inter-frame idle count.
//
// Build option:
//   SHIFT_REG_PISO_PARITY_EN - when defined, every frame carries one extra
//                              even-parity bit after the word's LSB.
// -----------------------------------------------------------------------------
package shift_reg_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      GAP   = 2'd2
   } state_t;

`ifdef SHIFT_REG_PISO_PARITY_EN
   localparam int PARITY_BITS = 1;
`else
   localparam int PARITY_BITS = 0;
`endif

   // Serial bits per frame: the data word plus the optional parity trailer.
   function automatic int frame_len(input int width);
      return width + PARITY_BITS;
   endfunction

   // The same counter walks the frame bits (0..frame_len-1) and the idle gap
   // (0..idle_cycles-1), so it is sized for whichever range is larger.
   function automatic int cnt_w(input int width, input int idle_cycles);
      int need;
      need = (frame_len(width) > idle_cycles) ? frame_len(width) : idle_cycles;
      return (need < 2) ? 1 : $clog2(need + 1);
   endfunction

endpackage

// File: rtl/shift_reg_piso_cnt.sv
// -----------------------------------------------------------------------------
// shift_reg_piso_cnt
//
// Loadable up-counter with terminal-count flag. The transmitter uses one
// instance for both the bit index inside a frame and the idle count between
// frames; the terminal value is selected by the caller each cycle.
//
// Parameters:
//   CNT_W   - counter width in bits.
//
// Ports:
//   clk     in   rising-edge clock
//   reset_n in   asynchronous active-low reset, clears the count
//   clr     in   synchronous clear to zero (has priority over inc)
//   inc     in   advance the count by one
//   term    in   terminal value to compare against
//   cnt     out  current count
//   tc      out  high while cnt equals term
// -----------------------------------------------------------------------------
module shift_reg_piso_cnt #(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clr,
   input  logic             inc,
   input  logic [CNT_W-1:0] term,
   output logic [CNT_W-1:0] cnt,
   output logic             tc
);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   assign tc = (cnt == term);

endmodule

// File: rtl/shift_reg_piso_tx.sv
// -----------------------------------------------------------------------------
// shift_reg_piso_tx
//
// Parallel-in, serial-out transmitter for the serial shift-register link.
// A WIDTH-bit word is accepted on a valid/ready handshake and shifted out
// MSB-first on sdo, one bit per clock, with sfrm high for every bit of the
// frame so the receiving end can align words. With IDLE_CYCLES==0 a new word
// may be taken on the last bit of the current frame, giving back-to-back
// frames with no bubble. With IDLE_CYCLES>0 a forced quiet gap follows every
// frame.
//
// Parameters:
//   WIDTH       - data word width in bits (>= 2)
//   IDLE_CYCLES - forced idle clocks between frames (0..15)
//
// Ports:
//   clk        in   rising-edge clock
//   reset_n    in   asynchronous active-low reset
//   din        in   [WIDTH] parallel word to transmit
//   din_valid  in   producer has a word on din
//   din_ready  out  word can be taken this cycle (combinational, 0 in reset)
//   sdo        out  serial data, MSB first (registered)
//   sfrm       out  frame strobe, high for every frame bit (registered)
//   busy       out  high while in SHIFT or GAP (registered)
//
// Build option:
//   SHIFT_REG_PISO_PARITY_EN - when defined, an even-parity bit (XOR of the
//   word) follows the LSB with sfrm still high, making frames WIDTH+1 long.
//   The last-bit ready / back-to-back rule then applies to the parity bit.
//   When undefined, frames are WIDTH bits and no parity logic exists.
// -----------------------------------------------------------------------------
module shift_reg_piso_tx
   import shift_reg_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter int IDLE_CYCLES = 0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   output logic             sdo,
   output logic             sfrm,
   output logic             busy
);

   localparam int               FRAME_LEN = frame_len(WIDTH);
   localparam int               CNT_W     = cnt_w(WIDTH, IDLE_CYCLES);
   localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(FRAME_LEN - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((IDLE_CYCLES > 0) ? IDLE_CYCLES - 1 : 0);
   localparam bit               NO_GAP    = (IDLE_CYCLES == 0);

   state_t                 state;
   state_t                 state_nxt;

   logic [FRAME_LEN-1:0]   sreg;
   logic [FRAME_LEN-1:0]   load_word;
   logic                   load;
   logic                   shift;

   logic                   sfrm_q;
   logic                   sfrm_nxt;
   logic                   busy_q;
   logic                   busy_nxt;

   logic                   cnt_clr;
   logic                   cnt_inc;
   logic [CNT_W-1:0]       cnt_term;
   logic [CNT_W-1:0]       cnt;
   logic                   cnt_tc;

   logic                   xfer;

   // Word as it enters the shift register; the parity trailer, when built in,
   // rides in the LSB position so it falls out right after the data LSB.
`ifdef SHIFT_REG_PISO_PARITY_EN
   assign load_word = {din, ^din};
`else
   assign load_word = din;
`endif

   // Ready is open in IDLE and, for gapless links, on the last frame bit so
   // the next word loads without a bubble. Reset forces it low so nothing is
   // accepted while reset_n is asserted.
   assign din_ready = reset_n &&
                      ((state == IDLE) || ((state == SHIFT) && cnt_tc && NO_GAP));
   assign xfer      = din_valid && din_ready;

   shift_reg_piso_cnt #(
      .CNT_W (CNT_W)
   ) u_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (cnt_clr),
      .inc     (cnt_inc),
      .term    (cnt_term),
      .cnt     (cnt),
      .tc      (cnt_tc)
   );

   // FSM state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state, datapath controls and next values of the registered strobes
   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      shift     = 1'b0;
      cnt_clr   = 1'b0;
      cnt_inc   = 1'b0;
      cnt_term  = LAST_BIT;
      sfrm_nxt  = sfrm_q;
      busy_nxt  = busy_q;

      unique case (state)
         IDLE: begin
            if (xfer) begin
               load      = 1'b1;
               cnt_clr   = 1'b1;
               sfrm_nxt  = 1'b1;
               busy_nxt  = 1'b1;
               state_nxt = SHIFT;
            end
         end

         SHIFT: begin
            if (!cnt_tc) begin
               shift   = 1'b1;
               cnt_inc = 1'b1;
            end else if (xfer) begin
               // Back-to-back: new word replaces the finished one, strobe stays up.
               load    = 1'b1;
               cnt_clr = 1'b1;
            end else begin
               // Final shift flushes the register to zero, so sdo idles low.
               shift    = 1'b1;
               cnt_clr  = 1'b1;
               sfrm_nxt = 1'b0;
               if (NO_GAP) begin
                  busy_nxt  = 1'b0;
                  state_nxt = IDLE;
               end else begin
                  busy_nxt  = 1'b1;
                  state_nxt = GAP;
               end
            end
         end

         GAP: begin
            cnt_term = GAP_LAST;
            if (cnt_tc) begin
               cnt_clr   = 1'b1;
               busy_nxt  = 1'b0;
               state_nxt = IDLE;
            end else begin
               cnt_inc = 1'b1;
            end
         end

         default: begin
            cnt_clr   = 1'b1;
            sfrm_nxt  = 1'b0;
            busy_nxt  = 1'b0;
            state_nxt = IDLE;
         end
      endcase
   end

   // Shift register and output strobes
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sreg   <= '0;
         sfrm_q <= 1'b0;
         busy_q <= 1'b0;
      end else begin
         if (load) begin
            sreg <= load_word;
         end else if (shift) begin
            sreg <= {sreg[FRAME_LEN-2:0], 1'b0};
         end
         sfrm_q <= sfrm_nxt;
         busy_q <= busy_nxt;
      end
   end

   // sdo is the register MSB itself, so it is a flop output with no extra stage.
   assign sdo  = sreg[FRAME_LEN-1];
   assign sfrm = sfrm_q;
   assign busy = busy_q;

endmodule

// File: tb/tb_shift_reg_piso_tx.sv
module tb_shift_reg_piso_tx;

`ifdef SHIFT_REG_PISO_PARITY_EN
   localparam int FLEN = 9;
`else
   localparam int FLEN = 8;
`endif

   logic       clk;
   logic       rst0_n, rst3_n;
   logic [7:0] din0, din3;
   logic       vld0, vld3;
   logic       rdy0, rdy3;
   logic       sdo0, sdo3;
   logic       sfrm0, sfrm3;
   logic       busy0, busy3;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      string           tag;
      logic [7:0]      din;
      logic [FLEN-1:0] exp;   // serial bits, leftmost sent first
   } vec_t;

   vec_t vecs[4];

   logic [FLEN-1:0] exp_ff, exp_00, exp_c3, exp_3c, exp_81;

   shift_reg_piso_tx #(.WIDTH(8), .IDLE_CYCLES(0)) u0 (
      .clk(clk), .reset_n(rst0_n), .din(din0), .din_valid(vld0),
      .din_ready(rdy0), .sdo(sdo0), .sfrm(sfrm0), .busy(busy0)
   );

   shift_reg_piso_tx #(.WIDTH(8), .IDLE_CYCLES(3)) u3 (
      .clk(clk), .reset_n(rst3_n), .din(din3), .din_valid(vld3),
      .din_ready(rdy3), .sdo(sdo3), .sfrm(sfrm3), .busy(busy3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle0(input string tag);
      chk({tag, ".sdo"},  sdo0,  1'b0);
      chk({tag, ".sfrm"}, sfrm0, 1'b0);
      chk({tag, ".busy"}, busy0, 1'b0);
      chk({tag, ".rdy"},  rdy0,  1'b1);
   endtask

   // Called in the cycle right after the transfer edge; walks the whole frame.
   task automatic frame0(input logic [FLEN-1:0] exp, input string tag);
      for (int b = 0; b < FLEN; b++) begin
         chk($sformatf("%s.sdo[%0d]", tag, b),  sdo0,  exp[FLEN-1-b]);
         chk($sformatf("%s.sfrm[%0d]", tag, b), sfrm0, 1'b1);
         chk($sformatf("%s.busy[%0d]", tag, b), busy0, 1'b1);
         chk($sformatf("%s.rdy[%0d]", tag, b),  rdy0,  (b == FLEN-1));
         step();
      end
   endtask

   task automatic frame3(input logic [FLEN-1:0] exp, input string tag);
      for (int b = 0; b < FLEN; b++) begin
         chk($sformatf("%s.sdo[%0d]", tag, b),  sdo3,  exp[FLEN-1-b]);
         chk($sformatf("%s.sfrm[%0d]", tag, b), sfrm3, 1'b1);
         chk($sformatf("%s.busy[%0d]", tag, b), busy3, 1'b1);
         chk($sformatf("%s.rdy[%0d]", tag, b),  rdy3,  1'b0);
         step();
      end
   endtask

   task automatic gap3(input string tag);
      for (int g = 0; g < 3; g++) begin
         chk($sformatf("%s.gap_sdo[%0d]", tag, g),  sdo3,  1'b0);
         chk($sformatf("%s.gap_sfrm[%0d]", tag, g), sfrm3, 1'b0);
         chk($sformatf("%s.gap_busy[%0d]", tag, g), busy3, 1'b1);
         chk($sformatf("%s.gap_rdy[%0d]", tag, g),  rdy3,  1'b0);
         step();
      end
   endtask

   initial begin
      // Directed vectors: word and the hand-derived serial bit sequence.
`ifdef SHIFT_REG_PISO_PARITY_EN
      vecs[0] = '{"v07", 8'h07, 9'b0000_0111_1};
      vecs[1] = '{"v03", 8'h03, 9'b0000_0011_0};
      vecs[2] = '{"vA5", 8'hA5, 9'b1010_0101_0};
      vecs[3] = '{"v6E", 8'h6E, 9'b0110_1110_1};
      exp_ff = 9'b1111_1111_0;
      exp_00 = 9'b0000_0000_0;
      exp_c3 = 9'b1100_0011_0;
      exp_3c = 9'b0011_1100_0;
      exp_81 = 9'b1000_0001_0;
`else
      vecs[0] = '{"vA5", 8'hA5, 8'b1010_0101};
      vecs[1] = '{"v01", 8'h01, 8'b0000_0001};
      vecs[2] = '{"v80", 8'h80, 8'b1000_0000};
      vecs[3] = '{"v6E", 8'h6E, 8'b0110_1110};
      exp_ff = 8'b1111_1111;
      exp_00 = 8'b0000_0000;
      exp_c3 = 8'b1100_0011;
      exp_3c = 8'b0011_1100;
      exp_81 = 8'b1000_0001;
`endif

      rst0_n = 1'b0; rst3_n = 1'b0;
      din0 = 8'h00;  din3 = 8'h00;
      vld0 = 1'b0;   vld3 = 1'b0;

      // Reset state, with din_valid asserted during reset (must be ignored)
      repeat (2) step();
      chk("rst.sdo",  sdo0,  1'b0);
      chk("rst.sfrm", sfrm0, 1'b0);
      chk("rst.busy", busy0, 1'b0);
      chk("rst.rdy",  rdy0,  1'b0);
      chk("rst.rdy3", rdy3,  1'b0);
      din0 = 8'hFF; vld0 = 1'b1;
      step();
      chk("rst_vld.busy", busy0, 1'b0);
      chk("rst_vld.rdy",  rdy0,  1'b0);
      vld0 = 1'b0;
      rst0_n = 1'b1; rst3_n = 1'b1;
      #1;
      idle0("post_rst");
      chk("post_rst.rdy3", rdy3, 1'b1);
      step();

      // Single frames from the vector table
      for (int i = 0; i < 4; i++) begin
         din0 = vecs[i].din; vld0 = 1'b1;
         chk({vecs[i].tag, ".rdy_pre"}, rdy0, 1'b1);
         step();
         vld0 = 1'b0; din0 = ~vecs[i].din;
         frame0(vecs[i].exp, vecs[i].tag);
         idle0({vecs[i].tag, ".after"});
         step();
      end

      // Back-to-back FF then 00 with valid held: the second word waits
      // through the first frame and loads on its last bit.
      din0 = 8'hFF; vld0 = 1'b1;
      step();
      din0 = 8'h00;
      frame0(exp_ff, "b2b_ff");
      vld0 = 1'b0;
      frame0(exp_00, "b2b_00");
      idle0("b2b.after");
      step();
      idle0("b2b.no_dup");

      // Reset in the middle of a frame
      din0 = 8'hC3; vld0 = 1'b1;
      step();
      vld0 = 1'b0;
      for (int b = 0; b < 3; b++) begin
         chk($sformatf("midrst.sdo[%0d]", b), sdo0, exp_c3[FLEN-1-b]);
         step();
      end
      #2;
      rst0_n = 1'b0;
      #1;
      chk("midrst.sdo",  sdo0,  1'b0);
      chk("midrst.sfrm", sfrm0, 1'b0);
      chk("midrst.busy", busy0, 1'b0);
      chk("midrst.rdy",  rdy0,  1'b0);
      step();
      chk("midrst.hold_sdo", sdo0, 1'b0);
      chk("midrst.hold_rdy", rdy0, 1'b0);
      rst0_n = 1'b1;
      #1;
      idle0("midrst.rel");
      din0 = 8'h3C; vld0 = 1'b1;
      step();
      vld0 = 1'b0;
      frame0(exp_3c, "v3C");
      idle0("v3C.after");

      // IDLE_CYCLES=3: two frames of 81, valid held throughout
      din3 = 8'h81; vld3 = 1'b1;
      chk("gap.rdy_pre", rdy3, 1'b1);
      step();
      frame3(exp_81, "gap_w1");
      gap3("gap_w1");
      chk("gap.idle_sdo",  sdo3,  1'b0);
      chk("gap.idle_sfrm", sfrm3, 1'b0);
      chk("gap.idle_busy", busy3, 1'b0);
      chk("gap.idle_rdy",  rdy3,  1'b1);
      step();
      vld3 = 1'b0;
      frame3(exp_81, "gap_w2");
      gap3("gap_w2");
      chk("gap.end_busy", busy3, 1'b0);
      chk("gap.end_sfrm", sfrm3, 1'b0);
      chk("gap.end_rdy",  rdy3,  1'b1);
      step();
      chk("gap.no_dup", busy3, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
